// File: rtl/pwm_sched_pkg.sv
// -----------------------------------------------------------------------------
// pwm_sched_pkg
// Shared types and constants for the PWM update scheduler.
//   state_t      : scheduler FSM states (IDLE, PENDING, APPLY)
//   event_sel_t  : update-point encodings for event_sel
//   DUTY_W       : width of one duty lane / carrier_max
//   clamp_duty() : limits a requested duty to the requested carrier_max
// -----------------------------------------------------------------------------
package pwm_sched_pkg;

   localparam int DUTY_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      APPLY   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EV_LOW   = 2'd0,
      EV_HIGH  = 2'd1,
      EV_BOTH  = 2'd2,
      EV_IMMED = 2'd3
   } event_sel_t;

   // Unsigned compare: a duty above the period would never toggle the output.
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] i_duty,
                                                     input logic [DUTY_W-1:0] i_max);
      return (i_duty > i_max) ? i_max : i_duty;
   endfunction

endpackage

// File: rtl/sched_edge_detect.sv
// -----------------------------------------------------------------------------
// sched_edge_detect
// Rising-edge detector for one carrier flag. A flag held high for several
// cycles produces a single o_rise pulse in the first cycle it is seen high.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flag     : carrier flag input
//   o_rise     : combinational pulse, i_flag high and previous sample low
// -----------------------------------------------------------------------------
module sched_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_flag,
   output logic o_rise
);

   logic r_prev;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b0;
      else        r_prev <= i_flag;
   end

   assign o_rise = i_flag & ~r_prev;

endmodule

// File: rtl/pwm_update_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_update_scheduler
// Accepts a new PWM setting (carrier_max, divider, per-leg duty) through a
// valid/ready handshake, holds it in shadow registers and applies all fields
// atomically on the selected carrier event (low, high, either, or immediate).
// Optional macro PWM_SCHED_TRIG_EN adds an event ratio counter driving trig.
//
// Ports
//   clk, rst_n        : 50 MHz clock, asynchronous active-low reset
//   carrier_low/high  : carrier-at-zero / carrier-at-max flags
//   event_sel         : 0=low, 1=high, 2=low or high, 3=immediate
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_carrier_max   : requested period, req_divider : requested divider
//   req_duty          : requested duty, 16 bits per leg, leg 0 in the LSBs
//   carrier_max, divider, duty : active settings
//   upd_done          : one-cycle pulse when the active settings change
//   trig              : one-cycle trigger every (trig_ratio+1) events
//   trig_ratio        : events per trig minus 1 (ignored without the macro)
// -----------------------------------------------------------------------------
module pwm_update_scheduler
   import pwm_sched_pkg::*;
#(
   parameter int          NUM_LEGS        = 3,
   parameter logic [15:0] RST_CARRIER_MAX = 16'd1000,
   parameter logic [7:0]  RST_DIVIDER     = 8'd4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       carrier_low,
   input  logic                       carrier_high,
   input  logic [1:0]                 event_sel,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [15:0]                req_carrier_max,
   input  logic [7:0]                 req_divider,
   input  logic [DUTY_W*NUM_LEGS-1:0] req_duty,
   output logic [15:0]                carrier_max,
   output logic [7:0]                 divider,
   output logic [DUTY_W*NUM_LEGS-1:0] duty,
   output logic                       upd_done,
   output logic                       trig,
   input  logic [3:0]                 trig_ratio
);

   state_t                     r_state, w_next_state;
   logic                       w_low_rise, w_high_rise, w_qual_event, w_capture;
   logic [15:0]                r_sh_max, r_act_max;
   logic [7:0]                 r_sh_div, r_act_div;
   logic [DUTY_W*NUM_LEGS-1:0] r_sh_duty, r_act_duty;
   logic                       r_upd_done;

   sched_edge_detect u_edge_low (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_flag (carrier_low),
      .o_rise (w_low_rise)
   );

   sched_edge_detect u_edge_high (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_flag (carrier_high),
      .o_rise (w_high_rise)
   );

   // Immediate mode still counts carrier_low edges for the trigger ratio.
   // Simultaneous low/high edges (carrier_max=0) OR into a single event.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_qual_event = w_low_rise;
      case (event_sel)
         EV_HIGH: w_qual_event = w_high_rise;
         EV_BOTH: w_qual_event = w_low_rise | w_high_rise;
         default: w_qual_event = w_low_rise;
      endcase
   end

   assign req_ready = (r_state == IDLE);
   assign w_capture = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_capture) w_next_state = PENDING;
         PENDING: if (event_sel == EV_IMMED || w_qual_event) w_next_state = APPLY;
         APPLY:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Shadow registers are cleared on reset so a discarded request leaves no
   // stale data behind; duty is clamped once here rather than on every apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_max  <= '0;
         r_sh_div  <= '0;
         r_sh_duty <= '0;
      end else if (w_capture) begin
         r_sh_max <= req_carrier_max;
         r_sh_div <= req_divider;
         for (int i = 0; i < NUM_LEGS; i++) begin
            r_sh_duty[i*DUTY_W +: DUTY_W] <= clamp_duty(req_duty[i*DUTY_W +: DUTY_W],
                                                         req_carrier_max);
         end
      end
   end

   // All active fields load on the same edge, together with upd_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_max  <= RST_CARRIER_MAX;
         r_act_div  <= RST_DIVIDER;
         r_act_duty <= '0;
         r_upd_done <= 1'b0;
      end else begin
         r_upd_done <= 1'b0;
         if (r_state == APPLY) begin
            r_act_max  <= r_sh_max;
            r_act_div  <= r_sh_div;
            r_act_duty <= r_sh_duty;
            r_upd_done <= 1'b1;
         end
      end
   end

   assign carrier_max = r_act_max;
   assign divider     = r_act_div;
   assign duty        = r_act_duty;
   assign upd_done    = r_upd_done;

`ifdef PWM_SCHED_TRIG_EN
   logic [3:0] r_ratio_cnt;

   // Counts every qualifying event independent of the FSM; trig fires in the
   // detection cycle of the event that reaches trig_ratio.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_ratio_cnt <= '0;
      else if (w_qual_event) r_ratio_cnt <= (r_ratio_cnt == trig_ratio) ? 4'd0
                                                                       : r_ratio_cnt + 4'd1;
   end

   assign trig = w_qual_event && (r_ratio_cnt == trig_ratio);
`else
   logic w_unused_trig_ratio;
   assign w_unused_trig_ratio = ^trig_ratio;
   assign trig = 1'b0;
`endif

endmodule
